v_decode_stage: RTL and testbench
=================================

Name: v_decode_stage

Overview:
- Registered, handshaked successor to the combinational vector decode.
- Decodes one vector instruction per accepted transfer and reads vector/scalar operands from the register files in the accept cycle.
- Element width (SEW 8/16/32) is runtime-configurable; scalar broadcast and widening are done per SEW.
- A per-register scoreboard stalls RAW/WAW hazards on vector registers until writeback. Sits between instruction fetch/issue and the VALU/vector-memory stage.

Parameters:
VALUOP_DW 5 VALU opcode width
VMEM_DW 512 vector memory data width
VMEM_AW 64 vector memory address width
VREG_DW 512 vector register width (multiple of 32)
VREG_AW 5 vector register address width
INST_DW 32 instruction width
REG_DW 64 scalar register width
REG_AW 5 scalar register address width
SEW_RST 2'b01 SEW code after reset (00=8, 01=16, 10=32)

Ports:
clk input 1 clock
rst input 1 synchronous active-high reset
in_valid_i input 1 instruction valid
in_ready_o output 1 stage accepts instruction
inst_i input INST_DW instruction
rs1_en_o/rs1_addr_o output 1/REG_AW scalar read port; rs1_dout_i input REG_DW, same-cycle data
vs1_en_o/vs1_addr_o output 1/VREG_AW vector read port 1; vs1_dout_i input VREG_DW
vs2_en_o/vs2_addr_o output 1/VREG_AW vector read port 2 (vs3 for stores); vs2_dout_i input VREG_DW
wb_valid_i input 1 vector writeback completed
wb_addr_i input VREG_AW register written back
out_valid_o output 1 decoded bundle valid
out_ready_i input 1 downstream accepts bundle
valu_opcode_o output VALUOP_DW NOP=0, MUL=1, ADD=2, DIV=3, MAX=4
sew_o output 2 SEW code bound to bundle
operand_v1_o/operand_v2_o output VREG_DW ALU operands
vmem_ren_o/vmem_wen_o output 1 vector load/store
vmem_addr_o output VMEM_AW address
vmem_din_o output VMEM_DW store data
vid_wb_en_o/vid_wb_sel_o output 1 writeback enable; select (1 = memory)
vid_wb_addr_o output VREG_AW vd
illegal_o output 1 bundle carries an illegal instruction; downstream drops it
sb_busy_o output 2**VREG_AW scoreboard state

Behaviour:
- Field decode:
  - opcode [6:0], vd [11:7], funct3 [14:12], vs1/rs1 [19:15], vs2 [24:20], funct7 [31:25].
  - imm5 = [19:15], sign-extended to SEW.
- Opcode 0000111 (load):
  - Reads rs1; addr = rs1_dout_i; ren = 1; wb_en = 1; wb_sel = 1.
- Opcode 0100111 (store):
  - Reads rs1, and vs3 = vd via vs2 port; addr = rs1_dout_i; din = vs2_dout_i; wen = 1.
- Opcode 1010111 with funct3 111 (vsetsew):
  - SEW register <= inst[21:20] on accept; code 11 is illegal and leaves SEW unchanged.
  - Produces no bundle.
- Opcode 1010111, other funct3; wb_en = 1; operand_v2 from vs2. funct7/funct3 map:
  - funct7 0 = MUL (vv funct3 000, vx 100, vi 011). Widening: each element of the low VREG_DW/2 bits of vs1/vs2 (width SEW/2, lowest element at LSB) is sign-extended to SEW. The vx scalar is rs1[SEW/2-1:0] sign-extended to SEW. MUL at SEW=8 is illegal.
  - funct7 1 = ADD (vv/vx/vi). Vectors are taken raw; the vx scalar is rs1[SEW-1:0] replicated VREG_DW/SEW times.
  - funct7 2 = DIV, vx only.
  - funct7 3 = MAX, vi only.
  - Any other combination is illegal: bundle issued with illegal_o = 1, all enables 0, opcode NOP, and no scoreboard set.
- Read enables assert only for the operands the instruction uses. Unused outputs are 0.
- Handshake:
  - hazard = any enabled vs1/vs2/vs3 read, or (vid_wb_en and vd), whose sb bit is set and is not cleared by wb this cycle.
  - in_ready_o = !hazard && (!out_valid_o || out_ready_i).
  - Accept = in_valid_i && in_ready_o. All outputs are registered on accept, giving 1-cycle latency.
  - out_valid_o holds, with the bundle stable, until out_ready_i. It drops after transfer if there is no new accept.
- Scoreboard:
  - Bit vd is set on accepting a wb_en instruction.
  - Bit wb_addr_i is cleared on wb_valid_i.
  - Same-cycle set and clear of the same register: set wins.
  - Clear of a non-busy bit: no effect.
- Reset: out_valid_o = 0, all bundle outputs = 0, sb = 0, SEW = SEW_RST. Reset during a stall discards the pending instruction and the bundle.

Test Plan:
- Reset, then vadd.vv v3,v1,v2 at SEW16 with vs1 = all 0x0001, vs2 = all 0x0002 -> out_valid_o after 1 cycle, opcode 2, operands passed raw, sb_busy_o[3] = 1.
- Hold out_ready_i = 0 for 3 cycles with a second instruction pending -> bundle stable, in_ready_o = 0. Release -> second bundle appears the next cycle.
- RAW: vadd into v3, then vmul.vv reading v3 -> in_ready_o = 0 until wb_valid_i with addr 3. Accepted in the same cycle as the wb.
- vsetsew 10, then vadd.vx with rs1 = 0x1_2345_6789 -> operand_v1 = 0x23456789 ×16. vmax.vi imm = -1 -> operand_v1 all 0xFFFFFFFF.
- vsetsew 00, then vmul.vv -> illegal_o = 1, opcode NOP, sb unchanged. vsetsew 11 -> SEW stays 8.
- Store with vd = 5 while v5 is busy -> stalls. After wb of 5 -> vs2_addr_o = 5, wen = 1, din = v5, addr = rs1.

Source files
------------

// File: rtl/v_decode_stage.sv
// Registered vector decode: field decode, same-cycle operand read, SEW-aware broadcast/widening, RAW/WAW scoreboard.
// Latency: one cycle from accept to out_valid_o.
// Backpressure: the bundle holds until out_ready_i; in_ready_o drops on a scoreboard hazard or a stalled full output.
module v_decode_stage #(
  parameter int VALUOP_DW = 5,
  parameter int VMEM_DW = 512,
  parameter int VMEM_AW = 64,
  parameter int VREG_DW = 512,
  parameter int VREG_AW = 5,
  parameter int INST_DW = 32,
  parameter int REG_DW = 64,
  parameter int REG_AW = 5,
  parameter logic [1:0] SEW_RST = 2'b01
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [INST_DW-1:0]      inst_i,
  output logic                    rs1_en_o,
  output logic [REG_AW-1:0]       rs1_addr_o,
  input  logic [REG_DW-1:0]       rs1_dout_i,
  output logic                    vs1_en_o,
  output logic [VREG_AW-1:0]      vs1_addr_o,
  input  logic [VREG_DW-1:0]      vs1_dout_i,
  output logic                    vs2_en_o,
  output logic [VREG_AW-1:0]      vs2_addr_o,
  input  logic [VREG_DW-1:0]      vs2_dout_i,
  input  logic                    wb_valid_i,
  input  logic [VREG_AW-1:0]      wb_addr_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [VALUOP_DW-1:0]    valu_opcode_o,
  output logic [1:0]              sew_o,
  output logic [VREG_DW-1:0]      operand_v1_o,
  output logic [VREG_DW-1:0]      operand_v2_o,
  output logic                    vmem_ren_o,
  output logic                    vmem_wen_o,
  output logic [VMEM_AW-1:0]      vmem_addr_o,
  output logic [VMEM_DW-1:0]      vmem_din_o,
  output logic                    vid_wb_en_o,
  output logic                    vid_wb_sel_o,
  output logic [VREG_AW-1:0]      vid_wb_addr_o,
  output logic                    illegal_o,
  output logic [2**VREG_AW-1:0]   sb_busy_o
);

  localparam int NREG = 2**VREG_AW;
  localparam logic [6:0] OPC_LD  = 7'b0000111;
  localparam logic [6:0] OPC_ST  = 7'b0100111;
  localparam logic [6:0] OPC_OPV = 7'b1010111;

  typedef struct packed {
    logic                 illegal;
    logic [VALUOP_DW-1:0] op;
    logic [1:0]           sew;
    logic [VREG_DW-1:0]   v1;
    logic [VREG_DW-1:0]   v2;
    logic                 ren;
    logic                 wen;
    logic [VMEM_AW-1:0]   addr;
    logic [VMEM_DW-1:0]   din;
    logic                 wb_en;
    logic                 wb_sel;
    logic [VREG_AW-1:0]   wb_addr;
  } bndl_t;

  // Sign-extend each SEW/2 element of the low half to SEW.
  function automatic logic [VREG_DW-1:0] widen(input logic [VREG_DW-1:0] v, input logic [1:0] sew);
    logic [VREG_DW-1:0] w16;
    logic [VREG_DW-1:0] w32;
    for (int i = 0; i < VREG_DW/16; i++) w16[i*16 +: 16] = {{8{v[i*8+7]}}, v[i*8 +: 8]};
    for (int i = 0; i < VREG_DW/32; i++) w32[i*32 +: 32] = {{16{v[i*16+15]}}, v[i*16 +: 16]};
    return (sew == 2'b10) ? w32 : w16;
  endfunction

  // Broadcast the low SEW bits of a scalar across the whole register.
  function automatic logic [VREG_DW-1:0] rep(input logic [31:0] s, input logic [1:0] sew);
    logic [VREG_DW-1:0] r;
    for (int i = 0; i < VREG_DW/8; i++) begin
      case (sew)
        2'b00:   r[i*8 +: 8] = s[7:0];
        2'b01:   r[i*8 +: 8] = s[(i%2)*8 +: 8];
        default: r[i*8 +: 8] = s[(i%4)*8 +: 8];
      endcase
    end
    return r;
  endfunction

  logic                  out_valid_q, out_valid_d;
  bndl_t                 bndl_q, bndl_d, dec;
  logic [1:0]            sew_q, sew_d;
  logic [NREG-1:0]       sb_q, sb_d, clr_mask, sb_eff;
  logic                  rs1_en, vs1_en, vs2_en, is_cfg, legal, hazard, accept;
  logic [VREG_AW-1:0]    vs2_addr;
  logic [6:0]            opc;
  logic [4:0]            vd, f_vs1, f_vs2;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [31:0]           imm32, s_raw32, s_half32;

  assign opc   = inst_i[6:0];
  assign vd    = inst_i[11:7];
  assign f3    = inst_i[14:12];
  assign f_vs1 = inst_i[19:15];
  assign f_vs2 = inst_i[24:20];
  assign f7    = inst_i[31:25];
  assign imm32    = {{27{inst_i[19]}}, inst_i[19:15]};
  assign s_raw32  = rs1_dout_i[31:0];
  assign s_half32 = (sew_q == 2'b10) ? {{16{rs1_dout_i[15]}}, rs1_dout_i[15:0]}
                                     : {{24{rs1_dout_i[7]}}, rs1_dout_i[7:0]};

  // Decode the presented instruction and build its bundle from same-cycle register reads.
  always_comb begin
    dec      = '0;
    dec.sew  = sew_q;
    rs1_en   = 1'b0;
    vs1_en   = 1'b0;
    vs2_en   = 1'b0;
    vs2_addr = f_vs2;
    is_cfg   = 1'b0;
    legal    = 1'b0;
    case (opc)
      OPC_LD: begin
        rs1_en      = 1'b1;
        dec.ren     = 1'b1;
        dec.wb_en   = 1'b1;
        dec.wb_sel  = 1'b1;
        dec.wb_addr = vd;
        dec.addr    = VMEM_AW'(rs1_dout_i);
      end
      OPC_ST: begin
        rs1_en   = 1'b1;
        vs2_en   = 1'b1;
        vs2_addr = vd;
        dec.wen  = 1'b1;
        dec.addr = VMEM_AW'(rs1_dout_i);
        dec.din  = VMEM_DW'(vs2_dout_i);
      end
      OPC_OPV: begin
        if (f3 == 3'b111) begin
          is_cfg = 1'b1;
        end else begin
          case (f7)
            7'd0: legal = (sew_q != 2'b00) && (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b011);
            7'd1: legal = (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b011);
            7'd2: legal = (f3 == 3'b100);
            7'd3: legal = (f3 == 3'b011);
            default: legal = 1'b0;
          endcase
          if (legal) begin
            dec.op      = (f7 == 7'd0) ? VALUOP_DW'(1) : (f7 == 7'd1) ? VALUOP_DW'(2) :
                          (f7 == 7'd2) ? VALUOP_DW'(3) : VALUOP_DW'(4);
            dec.wb_en   = 1'b1;
            dec.wb_addr = vd;
            vs2_en      = 1'b1;
            vs1_en      = (f3 == 3'b000);
            rs1_en      = (f3 == 3'b100);
            // MUL widens vectors and the vx scalar; everything else is raw.
            if (f7 == 7'd0) begin
              dec.v2 = widen(vs2_dout_i, sew_q);
              dec.v1 = (f3 == 3'b000) ? widen(vs1_dout_i, sew_q) :
                       (f3 == 3'b100) ? rep(s_half32, sew_q) : rep(imm32, sew_q);
            end else begin
              dec.v2 = vs2_dout_i;
              dec.v1 = (f3 == 3'b000) ? vs1_dout_i :
                       (f3 == 3'b100) ? rep(s_raw32, sew_q) : rep(imm32, sew_q);
            end
          end else begin
            dec.illegal = 1'b1;
          end
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Hazard check against the scoreboard, with this cycle's writeback already retired.
  always_comb begin
    clr_mask   = wb_valid_i ? (NREG'(1) << wb_addr_i) : '0;
    sb_eff     = sb_q & ~clr_mask;
    hazard     = in_valid_i && ((vs1_en && sb_eff[f_vs1]) || (vs2_en && sb_eff[vs2_addr]) ||
                                (dec.wb_en && sb_eff[vd]));
    in_ready_o = !hazard && (!out_valid_q || out_ready_i);
    accept     = in_valid_i && in_ready_o;
  end

  assign rs1_en_o   = in_valid_i && rs1_en;
  assign vs1_en_o   = in_valid_i && vs1_en;
  assign vs2_en_o   = in_valid_i && vs2_en;
  assign rs1_addr_o = rs1_en_o ? f_vs1 : '0;
  assign vs1_addr_o = vs1_en_o ? f_vs1 : '0;
  assign vs2_addr_o = vs2_en_o ? vs2_addr : '0;

  // Next state: bundle capture, SEW update, scoreboard set (set beats clear).
  always_comb begin
    out_valid_d = out_valid_q && !out_ready_i;
    bndl_d      = bndl_q;
    sew_d       = sew_q;
    sb_d        = sb_eff;
    if (accept) begin
      if (is_cfg) begin
        if (inst_i[21:20] != 2'b11) sew_d = inst_i[21:20];
      end else begin
        out_valid_d = 1'b1;
        bndl_d      = dec;
        if (dec.wb_en) sb_d[vd] = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bndl_q      <= '0;
      sew_q       <= SEW_RST;
      sb_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bndl_q      <= bndl_d;
      sew_q       <= sew_d;
      sb_q        <= sb_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign valu_opcode_o = bndl_q.op;
  assign sew_o         = bndl_q.sew;
  assign operand_v1_o  = bndl_q.v1;
  assign operand_v2_o  = bndl_q.v2;
  assign vmem_ren_o    = bndl_q.ren;
  assign vmem_wen_o    = bndl_q.wen;
  assign vmem_addr_o   = bndl_q.addr;
  assign vmem_din_o    = bndl_q.din;
  assign vid_wb_en_o   = bndl_q.wb_en;
  assign vid_wb_sel_o  = bndl_q.wb_sel;
  assign vid_wb_addr_o = bndl_q.wb_addr;
  assign illegal_o     = bndl_q.illegal;
  assign sb_busy_o     = sb_q;

endmodule

// File: tb/tb_v_decode_stage.sv
// Directed bench for v_decode_stage with register-file models on the read ports.
module tb_v_decode_stage;

  localparam logic [6:0] OPV = 7'b1010111;

  logic clk = 1'b0;
  logic rst;
  logic in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] inst_i;
  logic rs1_en_o, vs1_en_o, vs2_en_o;
  logic [4:0] rs1_addr_o, vs1_addr_o, vs2_addr_o, wb_addr_i, vid_wb_addr_o;
  logic [63:0] rs1_dout_i, vmem_addr_o;
  logic [511:0] vs1_dout_i, vs2_dout_i, operand_v1_o, operand_v2_o, vmem_din_o;
  logic wb_valid_i;
  logic [4:0] valu_opcode_o;
  logic [1:0] sew_o;
  logic vmem_ren_o, vmem_wen_o, vid_wb_en_o, vid_wb_sel_o, illegal_o;
  logic [31:0] sb_busy_o;

  logic [511:0] vreg [32];
  logic [63:0]  xreg [32];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign vs1_dout_i = vreg[vs1_addr_o];
  assign vs2_dout_i = vreg[vs2_addr_o];
  assign rs1_dout_i = xreg[rs1_addr_o];

  v_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .inst_i(inst_i),
    .rs1_en_o(rs1_en_o), .rs1_addr_o(rs1_addr_o), .rs1_dout_i(rs1_dout_i),
    .vs1_en_o(vs1_en_o), .vs1_addr_o(vs1_addr_o), .vs1_dout_i(vs1_dout_i),
    .vs2_en_o(vs2_en_o), .vs2_addr_o(vs2_addr_o), .vs2_dout_i(vs2_dout_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .valu_opcode_o(valu_opcode_o), .sew_o(sew_o),
    .operand_v1_o(operand_v1_o), .operand_v2_o(operand_v2_o),
    .vmem_ren_o(vmem_ren_o), .vmem_wen_o(vmem_wen_o), .vmem_addr_o(vmem_addr_o), .vmem_din_o(vmem_din_o),
    .vid_wb_en_o(vid_wb_en_o), .vid_wb_sel_o(vid_wb_sel_o), .vid_wb_addr_o(vid_wb_addr_o),
    .illegal_o(illegal_o), .sb_busy_o(sb_busy_o)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] vs2, input logic [4:0] vs1,
                                      input logic [2:0] f3, input logic [4:0] vd, input logic [6:0] op);
    return {f7, vs2, vs1, f3, vd, op};
  endfunction

  function automatic logic [31:0] vsetsew(input logic [1:0] s);
    return enc(7'd0, {3'b000, s}, 5'd0, 3'b111, 5'd0, OPV);
  endfunction

  // Present an instruction until accepted (bounded), then drop valid.
  task automatic issue(input logic [31:0] ins, input string tag);
    bit done;
    done = 1'b0;
    inst_i = ins;
    in_valid_i = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (in_ready_o) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    if (!done) chk(tag, in_ready_o, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      vreg[i] = '0;
      xreg[i] = '0;
    end
    vreg[1] = {32{16'h0001}};
    vreg[2] = {32{16'h0002}};
    vreg[3] = {64{8'h80}};
    vreg[5] = {16{32'hDEADBEEF}};
    xreg[7] = 64'h0000_0001_2345_6789;
    xreg[8] = 64'h0000_0000_8000_1000;
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1; wb_valid_i = 1'b0; wb_addr_i = '0; inst_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_sb", sb_busy_o, 32'h0);
    chk("rst_sew", sew_o, 2'b00);
    chk("rst_ready", in_ready_o, 1'b1);

    // vadd.vv v3,v1,v2 at SEW16
    inst_i = enc(7'd1, 5'd2, 5'd1, 3'b000, 5'd3, OPV);
    in_valid_i = 1'b1;
    #1;
    chk("add_vs1_en", vs1_en_o, 1'b1);
    chk("add_vs1_addr", vs1_addr_o, 5'd1);
    chk("add_rs1_en", rs1_en_o, 1'b0);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("add_valid", out_valid_o, 1'b1);
    chk("add_op", valu_opcode_o, 5'd2);
    chk("add_v1", operand_v1_o, {32{16'h0001}});
    chk("add_v2", operand_v2_o, {32{16'h0002}});
    chk("add_sew", sew_o, 2'b01);
    chk("add_sb", sb_busy_o, 32'h0000_0008);

    // Output stall with a second instruction pending
    out_ready_i = 1'b0;
    inst_i = enc(7'd1, 5'd2, 5'd1, 3'b000, 5'd4, OPV);
    in_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", in_ready_o, 1'b0);
      @(posedge clk); #1;
      chk("stall_valid", out_valid_o, 1'b1);
      chk("stall_vd", vid_wb_addr_o, 5'd3);
    end
    out_ready_i = 1'b1;
    #1;
    chk("release_ready", in_ready_o, 1'b1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("second_valid", out_valid_o, 1'b1);
    chk("second_vd", vid_wb_addr_o, 5'd4);
    chk("second_sb", sb_busy_o, 32'h0000_0018);
    @(posedge clk); #1;
    chk("drain_valid", out_valid_o, 1'b0);

    // RAW on v3: vmul.vv v6, vs1=v3, vs2=v1
    inst_i = enc(7'd0, 5'd1, 5'd3, 3'b000, 5'd6, OPV);
    in_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("raw_stall", in_ready_o, 1'b0);
      @(posedge clk); #1;
    end
    wb_valid_i = 1'b1; wb_addr_i = 5'd3;
    #1;
    chk("raw_wb_ready", in_ready_o, 1'b1);
    @(posedge clk); #1;
    in_valid_i = 1'b0; wb_valid_i = 1'b0;
    chk("mul_op", valu_opcode_o, 5'd1);
    chk("mul_v1_widen", operand_v1_o, {32{16'hFF80}});
    chk("mul_v2_widen", operand_v2_o, {16{32'h0000_0001}});
    chk("mul_sb", sb_busy_o, 32'h0000_0050);

    // Same-cycle set and clear of an idle register: set wins
    wb_valid_i = 1'b1; wb_addr_i = 5'd12;
    issue(enc(7'd1, 5'd2, 5'd1, 3'b000, 5'd12, OPV), "setwin_timeout");
    wb_valid_i = 1'b0;
    chk("setwin_sb", sb_busy_o, 32'h0000_1050);

    // SEW32 scalar broadcast and immediate
    issue(vsetsew(2'b10), "sew32_timeout");
    chk("cfg_no_bundle", out_valid_o, 1'b0);
    inst_i = enc(7'd1, 5'd2, 5'd7, 3'b100, 5'd7, OPV);
    in_valid_i = 1'b1;
    #1;
    chk("vx_rs1_en", rs1_en_o, 1'b1);
    chk("vx_vs1_en", vs1_en_o, 1'b0);
    issue(enc(7'd1, 5'd2, 5'd7, 3'b100, 5'd7, OPV), "vx_timeout");
    chk("vx_v1", operand_v1_o, {16{32'h2345_6789}});
    chk("vx_sew", sew_o, 2'b10);
    issue(enc(7'd3, 5'd2, 5'b11111, 3'b011, 5'd8, OPV), "max_timeout");
    chk("max_op", valu_opcode_o, 5'd4);
    chk("max_v1", operand_v1_o, {16{32'hFFFF_FFFF}});
    chk("max_sb", sb_busy_o, 32'h0000_11D0);

    // SEW8: MUL illegal, code 11 ignored, DIV broadcast of a byte
    issue(vsetsew(2'b00), "sew8_timeout");
    issue(enc(7'd0, 5'd2, 5'd1, 3'b000, 5'd9, OPV), "ill_timeout");
    chk("ill_flag", illegal_o, 1'b1);
    chk("ill_op", valu_opcode_o, 5'd0);
    chk("ill_wb_en", vid_wb_en_o, 1'b0);
    chk("ill_sb", sb_busy_o, 32'h0000_11D0);
    issue(vsetsew(2'b11), "sew11_timeout");
    issue(enc(7'd2, 5'd2, 5'd7, 3'b100, 5'd11, OPV), "div_timeout");
    chk("div_sew", sew_o, 2'b00);
    chk("div_op", valu_opcode_o, 5'd3);
    chk("div_v1", operand_v1_o, {64{8'h89}});
    chk("div_illegal", illegal_o, 1'b0);

    // Store of a busy register
    issue(enc(7'd1, 5'd2, 5'd1, 3'b000, 5'd5, OPV), "v5_timeout");
    chk("v5_sb", sb_busy_o, 32'h0000_19F0);
    inst_i = enc(7'd0, 5'd0, 5'd8, 3'b000, 5'd5, 7'b0100111);
    in_valid_i = 1'b1;
    #1;
    chk("st_stall", in_ready_o, 1'b0);
    @(posedge clk); #1;
    wb_valid_i = 1'b1; wb_addr_i = 5'd5;
    #1;
    chk("st_ready", in_ready_o, 1'b1);
    chk("st_vs3_addr", vs2_addr_o, 5'd5);
    chk("st_rs1_addr", rs1_addr_o, 5'd8);
    @(posedge clk); #1;
    in_valid_i = 1'b0; wb_valid_i = 1'b0;
    chk("st_wen", vmem_wen_o, 1'b1);
    chk("st_ren", vmem_ren_o, 1'b0);
    chk("st_din", vmem_din_o, {16{32'hDEADBEEF}});
    chk("st_addr", vmem_addr_o, 64'h0000_0000_8000_1000);
    chk("st_wb_en", vid_wb_en_o, 1'b0);
    chk("st_sb", sb_busy_o, 32'h0000_19D0);

    // Load
    issue(enc(7'd0, 5'd0, 5'd8, 3'b000, 5'd13, 7'b0000111), "ld_timeout");
    chk("ld_ren", vmem_ren_o, 1'b1);
    chk("ld_sel", vid_wb_sel_o, 1'b1);
    chk("ld_vd", vid_wb_addr_o, 5'd13);
    chk("ld_sb", sb_busy_o, 32'h0000_39D0);

    // Reset during a stall
    out_ready_i = 1'b0;
    inst_i = enc(7'd1, 5'd13, 5'd1, 3'b000, 5'd14, OPV);
    in_valid_i = 1'b1;
    #1;
    chk("rs_stall", in_ready_o, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    chk("rs_valid", out_valid_o, 1'b0);
    chk("rs_sb", sb_busy_o, 32'h0);
    chk("rs_vd", vid_wb_addr_o, 5'd0);
    issue(enc(7'd0, 5'd2, 5'd1, 3'b000, 5'd15, OPV), "post_rst_timeout");
    chk("post_rst_legal", illegal_o, 1'b0);
    chk("post_rst_sew", sew_o, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
